// File: rtl/div_3_recon_seq_pkg.sv
// Shared sizing and state encoding for the divide-by-3 reconstruction block.
// Imported by the handshake interface, the chunk adder and the top.
package div3_recon_pkg;
    localparam int W      = 64;
    localparam int QW     = W - 1;
    localparam int RW     = 2;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = W / CHUNK;
    localparam int KW     = $clog2(NCHUNK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/div_3_recon_seq_if.sv
// Input/output handshake bundle for div_3_recon_seq.
// master = source/consumer side, slave = the reconstruction block.
interface div_3_recon_seq_if;
    import div3_recon_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [QW-1:0] IN_Q;
    logic [RW-1:0] IN_R;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  X_out;
    logic          err;

    modport master (
        output in_valid, IN_Q, IN_R, out_ready,
        input  in_ready, out_valid, X_out, err
    );

    modport slave (
        input  in_valid, IN_Q, IN_R, out_ready,
        output in_ready, out_valid, X_out, err
    );
endinterface

// File: rtl/div_3_recon_seq_chunk_add.sv
// Combinational CHUNK-bit three-operand adder: two data chunks plus a 2-bit carry.
// The carry-out never exceeds 3, so two bits are always enough.
module recon_chunk_add
    import div3_recon_pkg::*;
(
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic [1:0]       i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic [1:0]       o_cout
);
    logic [CHUNK+1:0] w_total;

    assign w_total = (CHUNK+2)'(i_a) + (CHUNK+2)'(i_b) + (CHUNK+2)'(i_cin);
    assign o_sum   = w_total[CHUNK-1:0];
    assign o_cout  = w_total[CHUNK+1:CHUNK];
endmodule

// File: rtl/div_3_recon_seq.sv
// Rebuilds X = 3*Q + R (mod 2^W) one CHUNK per cycle, valid/ready on both sides.
// Optional consistency flag enabled by macro DIV3_RECON_CHECK_EN.
module div_3_recon_seq
    import div3_recon_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    div_3_recon_seq_if.slave    io_bus
);
    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [W-1:0]     r_q;
    logic [W-1:0]     r_q2;
    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_x;
    logic [1:0]       r_carry;
    logic [KW-1:0]    r_k;

    logic [CHUNK-1:0] w_sum;
    logic [1:0]       w_cout;
    logic [W-1:0]     w_acc_next;
    logic             w_accept;
    logic             w_last;

    // Operands shift right each CALC cycle, so chunk k always sits in the low bits.
    recon_chunk_add u_add (
        .i_a    (r_q[CHUNK-1:0]),
        .i_b    (r_q2[CHUNK-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_acc_next = {w_sum, r_acc[W-1:CHUNK]};
    assign w_accept   = (r_state == IDLE) && io_bus.in_valid && r_in_ready;
    assign w_last     = (r_k == KW'(NCHUNK-1));

`ifdef DIV3_RECON_CHECK_EN
    logic r_err;
    logic r_rbad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err  <= 1'b0;
            r_rbad <= 1'b0;
        end else if (w_accept) begin
            r_err  <= 1'b0;
            r_rbad <= (io_bus.IN_R >= RW'(3));
        end else if (r_state == CALC && w_last) begin
            r_err  <= r_rbad || (w_cout != 2'd0);
        end
    end

    assign io_bus.err = r_err;
`else
    assign io_bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_q2        <= '0;
            r_acc       <= '0;
            r_x         <= '0;
            r_carry     <= '0;
            r_k         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_q        <= {1'b0, io_bus.IN_Q};
                        r_q2       <= {io_bus.IN_Q, 1'b0};
                        r_carry    <= io_bus.IN_R;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_q     <= r_q  >> CHUNK;
                    r_q2    <= r_q2 >> CHUNK;
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_k     <= r_k + 1'b1;
                    // Final carry is discarded: the result wraps mod 2^W.
                    if (w_last) begin
                        r_x         <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.X_out     = r_x;
endmodule

// File: tb/tb_div_3_recon_seq.sv
// Randomised and directed bench for div_3_recon_seq against a plain-arithmetic model of 3*Q+R.
// Error-flag expectations follow DIV3_RECON_CHECK_EN as defined for the build.
module tb_div_3_recon_seq;
    import div3_recon_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    div_3_recon_seq_if bus ();

    div_3_recon_seq dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_x(input logic [QW-1:0] q, input logic [RW-1:0] r);
        logic [W+1:0] full;
        full = 3 * {3'b000, q} + {{W{1'b0}}, r};
        return full[W-1:0];
    endfunction

    function automatic logic model_err(input logic [QW-1:0] q, input logic [RW-1:0] r);
        logic [W+1:0] full;
        full = 3 * {3'b000, q} + {{W{1'b0}}, r};
`ifdef DIV3_RECON_CHECK_EN
        return (r >= 2'd3) || (full[W+1:W] != 2'b00);
`else
        return 1'b0 && (full != 0);
`endif
    endfunction

    function automatic logic [QW-1:0] rand_q();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[QW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction with out_ready held high; reports result, latency and completion.
    task automatic run_txn(input logic [QW-1:0] q, input logic [RW-1:0] r,
                           output logic [W-1:0] x, output logic e, output int lat, output logic ok);
        int waitc;
        waitc = 0;
        ok    = 1'b0;
        x     = '0;
        e     = 1'b0;
        lat   = 0;
        while (!bus.in_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        bus.IN_Q      = q;
        bus.IN_R      = r;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (bus.out_valid) begin
            ok = 1'b1;
            x  = bus.X_out;
            e  = bus.err;
        end
        tick();
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.IN_Q      = '1;
        bus.IN_R      = 2'd1;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.X_out !== '0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: in_ready=%b out_valid=%b X_out=%h err=%b, required 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.X_out, bus.err);
        end
    endtask

    task automatic test_directed();
        logic [QW-1:0] tq [7];
        logic [RW-1:0] tr [7];
        logic [W-1:0]  x;
        logic          e;
        logic          ok;
        int            lat;
        tq = '{63'h0, 63'h1234, 63'h5555, 63'h5555_5555_5555_5555, 63'h5555_5555_5555_5555, 63'h7, 63'h7};
        tr = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd1, 2'd3, 2'd0};
        for (int i = 0; i < 7; i++) begin
            run_txn(tq[i], tr[i], x, e, lat, ok);
            n_vec++;
            if (!ok || x !== model_x(tq[i], tr[i]) || e !== model_err(tq[i], tr[i])) begin
                n_bad++;
                $display("FAIL directed[%0d]: done=%b X_out=%h err=%b, required X_out=%h err=%b",
                         i, ok, x, e, model_x(tq[i], tr[i]), model_err(tq[i], tr[i]));
            end
            n_vec++;
            if (lat !== NCHUNK) begin
                n_bad++;
                $display("FAIL latency[%0d]: got %0d cycles, required %0d", i, lat, NCHUNK);
            end
        end
    endtask

    task automatic test_random();
        logic [QW-1:0] q;
        logic [RW-1:0] r;
        logic [W-1:0]  x;
        logic          e;
        logic          ok;
        int            lat;
        for (int i = 0; i < 40; i++) begin
            q = rand_q();
            r = RW'($urandom_range(0, 3));
            run_txn(q, r, x, e, lat, ok);
            n_vec++;
            if (!ok || x !== model_x(q, r) || e !== model_err(q, r)) begin
                n_bad++;
                $display("FAIL random[%0d] Q=%h R=%0d: done=%b X_out=%h err=%b, required X_out=%h err=%b",
                         i, q, r, ok, x, e, model_x(q, r), model_err(q, r));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [QW-1:0] q;
        logic [W-1:0]  x;
        logic          e;
        logic          ok;
        int            lat;
        int            waitc;
        q = rand_q();
        bus.IN_Q      = q;
        bus.IN_R      = 2'd2;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        waitc = 0;
        while (!bus.out_valid && waitc < 20) begin
            tick();
            waitc++;
        end
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = c[0];
            bus.IN_Q     = rand_q();
            bus.IN_R     = 2'd3;
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.X_out !== model_x(q, 2'd2) ||
                bus.err !== model_err(q, 2'd2) || bus.in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d]: out_valid=%b X_out=%h err=%b in_ready=%b, required 1 %h %b 0",
                         c, bus.out_valid, bus.X_out, bus.err, bus.in_ready, model_x(q, 2'd2), model_err(q, 2'd2));
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.X_out !== model_x(q, 2'd2)) begin
            n_bad++;
            $display("FAIL release: out_valid=%b in_ready=%b X_out=%h, required 0 1 %h",
                     bus.out_valid, bus.in_ready, bus.X_out, model_x(q, 2'd2));
        end
        q = rand_q();
        run_txn(q, 2'd1, x, e, lat, ok);
        n_vec++;
        if (!ok || x !== model_x(q, 2'd1)) begin
            n_bad++;
            $display("FAIL after_hold: done=%b X_out=%h, required %h", ok, x, model_x(q, 2'd1));
        end
    endtask

    task automatic test_reset_midcalc();
        logic [QW-1:0] q;
        logic [W-1:0]  x;
        logic          e;
        logic          ok;
        logic          seen;
        int            lat;
        run_txn(63'h1234, 2'd2, x, e, lat, ok);
        bus.IN_Q      = rand_q();
        bus.IN_R      = 2'd1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.X_out !== '0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_state: in_ready=%b out_valid=%b X_out=%h err=%b, required 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.X_out, bus.err);
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_pulse: out_valid seen=%b, required 0", seen);
        end
        q = rand_q();
        run_txn(q, 2'd0, x, e, lat, ok);
        n_vec++;
        if (!ok || x !== model_x(q, 2'd0) || e !== model_err(q, 2'd0)) begin
            n_bad++;
            $display("FAIL after_abort: done=%b X_out=%h err=%b, required %h %b",
                     ok, x, e, model_x(q, 2'd0), model_err(q, 2'd0));
        end
    endtask

    task automatic test_back_to_back();
        logic [QW-1:0] vq [3];
        logic [RW-1:0] vr [3];
        int            acc_cyc [3];
        int            idx;
        int            got;
        logic          acc;
        for (int i = 0; i < 3; i++) begin
            vq[i]      = rand_q();
            vr[i]      = RW'($urandom_range(0, 3));
            acc_cyc[i] = 0;
        end
        idx = 0;
        got = 0;
        bus.out_ready = 1'b1;
        bus.IN_Q      = vq[0];
        bus.IN_R      = vr[0];
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 40 && got < 3; c++) begin
            acc = bus.in_ready && bus.in_valid;
            if (bus.out_valid) begin
                n_vec++;
                if (bus.X_out !== model_x(vq[got], vr[got]) || bus.err !== model_err(vq[got], vr[got])) begin
                    n_bad++;
                    $display("FAIL b2b[%0d]: X_out=%h err=%b, required %h %b", got, bus.X_out, bus.err,
                             model_x(vq[got], vr[got]), model_err(vq[got], vr[got]));
                end
                got++;
            end
            tick();
            if (acc && idx < 3) begin
                acc_cyc[idx] = c;
                idx++;
                if (idx < 3) begin
                    bus.IN_Q = vq[idx];
                    bus.IN_R = vr[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (got != 3 || idx != 3) begin
            n_bad++;
            $display("FAIL b2b_count: accepted %0d results %0d, required 3 3", idx, got);
        end
        n_vec++;
        if (acc_cyc[1] - acc_cyc[0] != NCHUNK + 2 || acc_cyc[2] - acc_cyc[1] != NCHUNK + 2) begin
            n_bad++;
            $display("FAIL b2b_rate: accept spacing %0d %0d, required %0d",
                     acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], NCHUNK + 2);
        end
        tick();
    endtask

    initial begin
        n_vec         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.IN_Q      = '0;
        bus.IN_R      = '0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midcalc();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
